// File: rtl/alu_seq.sv
// alu_seq: sequential ALU. Simple ops finish in one cycle; multiply and
// divide run a one-bit-per-cycle shift-add / restoring-divide engine.
//
// Handshake: start is taken only while the FSM is IDLE (busy low). The edge
// that takes it latches ALUControl, a_in and b_in. busy stays high from that
// edge until the FSM returns to IDLE. done pulses for exactly one cycle, in
// the DONE state, and ALUResult/Z carry the new value from that cycle until
// the next done. Neither start nor operand changes while busy have any effect.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Z
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  // hi/lo hold the product (mul) or remainder/quotient (div); opnd is the
  // multiplicand (mul) or divisor (div).
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             z_q, z_d;

  logic [CW-1:0]    shamt;
  logic [WIDTH-1:0] single_res;
  logic             start_iter;
  logic             start_mul;
  logic             calc_mul;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_trial;
  logic [WIDTH-1:0] div_hi_nx, div_lo_nx;
  logic [WIDTH-1:0] step_hi, step_lo;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      z_q      <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      z_q      <= z_d;
    end
  end

  // Single-cycle result straight from the live inputs (used only on the accepting edge)
  always_comb begin
    shamt      = b_in[CW-1:0];
    single_res = '0;
    case (ALUControl)
      4'b0000: single_res = a_in + b_in;
      4'b0001: single_res = a_in - b_in;
      4'b0010: single_res = a_in & b_in;
      4'b0011: single_res = a_in | b_in;
      4'b0100: single_res = a_in ^ b_in;
      4'b0101: single_res = {{(WIDTH-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
      4'b0110: single_res = {{(WIDTH-1){1'b0}}, (a_in < b_in)};
      4'b0111: single_res = a_in << shamt;
      4'b1000: single_res = a_in >> shamt;
      4'b1001: single_res = $unsigned($signed(a_in) >>> shamt);
      default: single_res = '0;
    endcase
    start_iter = (ALUControl >= 4'b1010) && (ALUControl <= 4'b1101);
    start_mul  = (ALUControl[3:1] == 3'b101);
  end

  // One step of the shift-add multiplier and the restoring divider
  always_comb begin
    calc_mul  = (op_q[3:1] == 3'b101);
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    // When div_ge holds the true difference is below the divisor, so the
    // low WIDTH bits of the subtraction are exact.
    div_trial = div_shift[WIDTH-1:0] - opnd_q;
    div_hi_nx = div_ge ? div_trial : div_shift[WIDTH-1:0];
    div_lo_nx = {lo_q[WIDTH-2:0], div_ge};
    step_hi   = calc_mul ? mul_hi_nx : div_hi_nx;
    step_lo   = calc_mul ? mul_lo_nx : div_lo_nx;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = start_iter ? S_CALC : S_DONE;
      end
      S_CALC: begin
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath register updates: operand latch, iteration, result capture
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    z_d      = z_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = ALUControl;
          cnt_d = '0;
          if (start_iter) begin
            hi_d   = '0;
            lo_d   = start_mul ? b_in : a_in;
            opnd_d = start_mul ? a_in : b_in;
          end else begin
            result_d = single_res;
            z_d      = (single_res == '0);
          end
        end
      end
      S_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          // op bit 0 picks the upper half: mulhu (1011) and remu (1101)
          result_d = op_q[0] ? step_hi : step_lo;
          z_d      = ((op_q[0] ? step_hi : step_lo) == '0);
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state and result registers
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    ALUResult = result_q;
    Z         = z_q;
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, random ops against an arithmetic model,
// and hand-written sequences for busy, reset and back-to-back behaviour.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   ALUControl;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] ALUResult;
  logic         Z;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    int           lat;
  } vec_t;

  vec_t vecs[22];

  logic [W-1:0] exp_q[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .ALUControl(ALUControl),
    .a_in(a_in),
    .b_in(b_in),
    .busy(busy),
    .done(done),
    .ALUResult(ALUResult),
    .Z(Z)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the operation's definition
  function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic [63:0] p;
    int          sh;
    p  = {32'b0, a} * {32'b0, b};
    sh = int'(b % 32);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a << sh;
      4'd8:    return a >> sh;
      4'd9:    return $unsigned($signed(a) >>> sh);
      4'd10:   return p[31:0];
      4'd11:   return p[63:32];
      4'd12:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13:   return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // driver: issue one op from IDLE and wait (bounded) for done
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic z, output int lat);
    ALUControl = op;
    a_in       = a;
    b_in       = b;
    start      = 1'b1;
    lat        = 0;
    do begin
      tick();
      start = 1'b0;
      lat++;
    end while (!done && lat < 100);
    res = ALUResult;
    z   = Z;
  endtask

  initial begin
    logic [W-1:0] res;
    logic         z;
    int           lat;
    int           done_cnt;
    int           done_at;
    logic [W-1:0] got;
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;

    vecs[0]  = '{4'b0001, 32'd5,          32'd7,          32'hFFFF_FFFE, 1'b0, 1};
    vecs[1]  = '{4'b1001, 32'h8000_0000,  32'h24,         32'hF800_0000, 1'b0, 1};
    vecs[2]  = '{4'b1010, 32'h1_0000,     32'h1_0000,     32'h0,         1'b1, 33};
    vecs[3]  = '{4'b1011, 32'h1_0000,     32'h1_0000,     32'h1,         1'b0, 33};
    vecs[4]  = '{4'b1100, 32'd100,        32'd7,          32'd14,        1'b0, 33};
    vecs[5]  = '{4'b1101, 32'd100,        32'd7,          32'd2,         1'b0, 33};
    vecs[6]  = '{4'b1100, 32'd100,        32'd0,          32'hFFFF_FFFF, 1'b0, 33};
    vecs[7]  = '{4'b1101, 32'd9,          32'd0,          32'd9,         1'b0, 33};
    vecs[8]  = '{4'b0000, 32'hFFFF_FFFF,  32'd1,          32'h0,         1'b1, 1};
    vecs[9]  = '{4'b0010, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000, 1'b0, 1};
    vecs[10] = '{4'b0011, 32'h0F0F_0000,  32'h0000_00F0,  32'h0F0F_00F0, 1'b0, 1};
    vecs[11] = '{4'b0100, 32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555, 1'b0, 1};
    vecs[12] = '{4'b0101, 32'hFFFF_FFFF,  32'd1,          32'd1,         1'b0, 1};
    vecs[13] = '{4'b0110, 32'hFFFF_FFFF,  32'd1,          32'd0,         1'b1, 1};
    vecs[14] = '{4'b0111, 32'd1,          32'h21,         32'd2,         1'b0, 1};
    vecs[15] = '{4'b1000, 32'h8000_0000,  32'h1F,         32'd1,         1'b0, 1};
    vecs[16] = '{4'b1110, 32'd123,        32'd456,        32'd0,         1'b1, 1};
    vecs[17] = '{4'b1111, 32'd123,        32'd456,        32'd0,         1'b1, 1};
    vecs[18] = '{4'b1010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,         1'b0, 33};
    vecs[19] = '{4'b1011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 1'b0, 33};
    vecs[20] = '{4'b1100, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF, 1'b0, 33};
    vecs[21] = '{4'b1101, 32'hFFFF_FFFF,  32'd10,         32'd5,         1'b0, 33};

    // reset held for two cycles
    reset = 1'b1; start = 1'b0; ALUControl = '0; a_in = '0; b_in = '0;
    tick();
    tick();
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", ALUResult, 32'd0);
    check("reset_z", {31'b0, Z}, 32'd1);
    reset = 1'b0;
    tick();

    // directed vector table
    for (int i = 0; i < 22; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat);
      check($sformatf("vec%0d_res", i), res, vecs[i].res);
      check($sformatf("vec%0d_z", i), {31'b0, z}, {31'b0, vecs[i].z});
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      tick();
      check($sformatf("vec%0d_done_drop", i), {31'b0, done}, 32'd0);
      check($sformatf("vec%0d_idle", i), {31'b0, busy}, 32'd0);
    end
    check("result_held_in_idle", ALUResult, 32'd5);

    // randomized ops against the reference model
    for (int i = 0; i < 200; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      exp_q.push_back(ref_result(rop, ra, rb));
      run_op(rop, ra, rb, res, z, lat);
      got = exp_q.pop_front();
      check($sformatf("rand%0d_res op=%0h a=%08h b=%08h", i, rop, ra, rb), res, got);
      check($sformatf("rand%0d_z", i), {31'b0, z}, {31'b0, (got == 0)});
      check($sformatf("rand%0d_lat op=%0h", i, rop), lat,
            (rop >= 4'd10 && rop <= 4'd13) ? 33 : 1);
      tick();
    end

    // start and operand changes while busy are ignored
    ALUControl = 4'b1100; a_in = 32'd1000; b_in = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0; done_at = 0; got = '0;
    if (done) begin done_cnt++; done_at = 1; got = ALUResult; end
    for (int i = 0; i < 40; i++) begin
      if (i == 5) begin
        check("busy_mid_calc", {31'b0, busy}, 32'd1);
        start = 1'b1; ALUControl = 4'b0000; a_in = 32'd7; b_in = 32'd8;
      end
      if (i == 6) start = 1'b0;
      tick();
      if (done) begin done_cnt++; done_at = i + 2; got = ALUResult; end
    end
    check("busy_done_count", done_cnt, 32'd1);
    check("busy_done_cycle", done_at, 32'd33);
    check("busy_result", got, ref_result(4'b1100, 32'd1000, 32'd9));
    check("busy_back_idle", {31'b0, busy}, 32'd0);

    // start held high: one IDLE cycle between back-to-back ops
    ALUControl = 4'b0000; a_in = 32'd1; b_in = 32'd2; start = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) done_cnt++;
    end
    start = 1'b0;
    tick();
    check("held_start_done_count", done_cnt, 32'd3);
    check("held_start_result", ALUResult, 32'd3);

    // reset mid-operation aborts the multiply
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("pre_abort_result", ALUResult, 32'd0);
    ALUControl = 4'b1010; a_in = 32'd12345; b_in = 32'd678; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("abort_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_result", ALUResult, 32'd0);
    check("abort_z", {31'b0, Z}, 32'd1);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 32'd0);
    check("abort_result_kept", ALUResult, 32'd0);

    // reset wins over start on the same edge
    ALUControl = 4'b0000; a_in = 32'd4; b_in = 32'd4; start = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    check("reset_prio_busy", {31'b0, busy}, 32'd0);
    tick();
    check("reset_prio_done", {31'b0, done}, 32'd0);
    check("reset_prio_result", ALUResult, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width; legal values are powers of two, 8 to 64.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request a new operation; sampled only in IDLE.
REQ-005 SHALL have port ALUControl, input, 4: operation select, sampled with start.
REQ-006 SHALL have port a_in, input, WIDTH: operand A, sampled with start.
REQ-007 SHALL have port b_in, input, WIDTH: operand B, sampled with start.
REQ-008 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-009 SHALL have port done, output, 1: one-cycle pulse marking a valid ALUResult/Z.
REQ-010 SHALL have port ALUResult, output reg, WIDTH: registered result, held until the next done.
REQ-011 SHALL have port Z, output reg, 1: registered flag, (ALUResult == 0), updated together with ALUResult.

Function
REQ-012 SHALL implement states IDLE, CALC and DONE. Transitions: IDLE->DONE (start & single-cycle op); IDLE->CALC (start & iterative op); CALC->DONE after the final step; DONE->IDLE unconditionally.
REQ-013 SHALL decode single-cycle ops: 0000 add; 0001 sub (two's complement); 0010 and; 0011 or; 0100 xor; 0101 slt (signed, result 1/0); 0110 sltu (unsigned); 0111 sll; 1000 srl; 1001 sra.
REQ-014 SHALL use b_in[log2(WIDTH)-1:0] as the shift amount and ignore higher b_in bits.
REQ-015 SHALL decode iterative ops: 1010 mul (low WIDTH bits of the unsigned product); 1011 mulhu (high WIDTH bits); 1100 divu (quotient); 1101 remu (remainder).
REQ-016 SHALL treat codes 1110/1111 as single-cycle ops yielding ALUResult=0, Z=1.
REQ-017 SHALL wrap all add/sub/mul-low results modulo 2^WIDTH; no carry/overflow output.
REQ-018 SHALL latch a_in, b_in and ALUControl on the accepting edge; input changes after that edge SHALL NOT affect the result.
REQ-019 SHALL compute mul/mulhu by shift-add and divu/remu by restoring division, one bit per cycle, for exactly WIDTH CALC cycles (counter 0..WIDTH-1).
REQ-020 SHALL raise done for exactly one cycle after the accepting edge for single-cycle ops (latency 1); done SHALL appear WIDTH+1 cycles after the accepting edge for iterative ops.
REQ-021 SHALL ignore start while busy; no queuing, no effect on the operation in flight.
REQ-022 SHALL NOT accept start in DONE; back-to-back ops therefore need one IDLE cycle (start may be held high).
REQ-023 SHALL, for divu with b=0, return all ones; for remu with b=0, return a_in; both SHALL still take WIDTH+1 cycles.
REQ-024 SHALL leave ALUResult and Z unchanged except on the edge entering DONE.

Reset
REQ-025 SHALL, when reset is sampled high, force: state IDLE, counter 0, busy 0, done 0, ALUResult 0, Z 1.
REQ-026 SHALL let reset in CALC or DONE abort the operation: no done pulse and no result update afterward.
REQ-027 SHALL give reset priority over start on the same edge; that start is discarded.

Verification
REQ-028 Bench SHALL cover reset: assert reset 2 cycles -> busy=0, done=0, ALUResult=0, Z=1.
REQ-029 Bench SHALL cover single-cycle ops, WIDTH=32: start, sub, a=5, b=7 -> next cycle done=1, ALUResult=0xFFFFFFFE, Z=0; sra, a=0x80000000, b=0x24 -> ALUResult=0xF8000000.
REQ-030 Bench SHALL cover mul, WIDTH=32: start, mul, a=0x10000, b=0x10000 -> done after 33 cycles, ALUResult=0, Z=1; then mulhu, same operands -> ALUResult=1.
REQ-031 Bench SHALL cover divide: divu a=100, b=7 -> 14; remu -> 2; divu b=0 -> 0xFFFFFFFF; remu a=9, b=0 -> 9; each done at cycle 33.
REQ-032 Bench SHALL cover busy behaviour: start divu, then pulse start with add and change a_in/b_in mid-CALC -> ignored, divu result unchanged, exactly one done.
REQ-033 Bench SHALL cover reset mid-op: reset at CALC cycle 10 of mul -> IDLE next cycle, no done, ALUResult retains 0.
